// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// word geometry and the byte-strobe merge used by the storage array.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int WORD_BYTES = 4;

   // Replace the byte lanes of old_word selected by strb with those of new_word.
   function automatic logic [31:0] merge_bytes(input logic [31:0]           old_word,
                                               input logic [31:0]           new_word,
                                               input logic [WORD_BYTES-1:0] strb);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < WORD_BYTES; i++) begin
         if (strb[i]) begin
            res[i*8 +: 8] = new_word[i*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous byte-strobed write, combinational
// read by the same index. Contents survive reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      idx,
   input  logic [31:0]           wdata,
   input  logic [WORD_BYTES-1:0] wstrb,
   output logic [31:0]           rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Merge the enabled lanes into the addressed word on a write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= merge_bytes(mem[idx], wdata, wstrb);
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the core's load/store port. Accepts one request
// at a time, waits WAIT_STATES cycles, commits the access on the edge that
// enters RESP and holds the response until the initiator takes it.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * WORD_BYTES);
   localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t state, state_next;
   logic [3:0] cnt;

   logic accept;
   logic handshake;
   logic commit;

   // Live request decode; only meaningful on the accepting edge.
   logic [31:0]      req_offset;
   logic [IDX_W-1:0] req_idx;
   logic             req_err;

   // Request captured at acceptance, used when the commit happens later.
   logic             cap_we;
   logic [31:0]      cap_wdata;
   logic [3:0]       cap_wstrb;
   logic [IDX_W-1:0] cap_idx;
   logic             cap_err;

   // Selected commit source: live request with no wait states, capture otherwise.
   logic             cm_we;
   logic [31:0]      cm_wdata;
   logic [3:0]       cm_wstrb;
   logic [IDX_W-1:0] cm_idx;
   logic             cm_err;

   logic        arr_we;
   logic [31:0] arr_rdata;

   // Offset is taken modulo 2^32: an address below BASE_ADDR wraps to a value
   // at least SPAN because the window is aligned and never crosses 2^32.
   assign req_offset = req_addr - BASE_ADDR;
   assign req_idx    = IDX_W'(req_offset >> 2);
   assign req_err    = (req_addr[1:0] != 2'b00) || (req_offset >= SPAN);

   assign accept    = (state == ST_IDLE) && req_valid;
   assign handshake = (state == ST_RESP) && rsp_ready;
   assign commit    = (state != ST_RESP) && (state_next == ST_RESP);

   assign cm_we    = (state == ST_IDLE) ? req_we    : cap_we;
   assign cm_wdata = (state == ST_IDLE) ? req_wdata : cap_wdata;
   assign cm_wstrb = (state == ST_IDLE) ? req_wstrb : cap_wstrb;
   assign cm_idx   = (state == ST_IDLE) ? req_idx   : cap_idx;
   assign cm_err   = (state == ST_IDLE) ? req_err   : cap_err;

   // State register; reset drops any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (WAIT_STATES > 0) begin
                  state_next = ST_WAIT;
               end else begin
                  state_next = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Handshake outputs and storage write enable decoded from state.
   always_comb begin
      req_ready = (state == ST_IDLE);
      rsp_valid = (state == ST_RESP);
      arr_we    = commit && cm_we && !cm_err;
   end

   // Wait counter: loaded on acceptance, counts down to zero while waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 4'd0;
      end else if (accept) begin
         cnt <= CNT_LOAD;
      end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Capture the request on the accepting edge; later request changes are ignored.
   always_ff @(posedge clk) begin
      if (accept) begin
         cap_we    <= req_we;
         cap_wdata <= req_wdata;
         cap_wstrb <= req_wstrb;
         cap_idx   <= req_idx;
         cap_err   <= req_err;
      end
   end

   // Response registers: loaded at commit, held through backpressure, cleared after handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else if (commit) begin
         rsp_err   <= cm_err;
         rsp_rdata <= (!cm_we && !cm_err) ? arr_rdata : 32'h0;
      end else if (handshake) begin
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .idx   (cm_idx),
      .wdata (cm_wdata),
      .wstrb (cm_wstrb),
      .rdata (arr_rdata)
   );

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target for the core's load/store port. Answers requests on a valid/ready request channel and a valid/ready response channel.
- Inserts a configurable number of wait states so the core's memory stage can be exercised against non-zero latency.
- Owns the word-organised storage, applies byte write strobes, and flags misaligned or out-of-range accesses.
- One outstanding transaction at a time; no pipelining of requests.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; power of two, minimum 4.
- WAIT_STATES, 2, cycles between request acceptance and response; range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, lane-aligned
- req_wstrb  in  4  byte enables for stores; bit i enables byte lane i; ignored for loads
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts response
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  access was misaligned or out of range

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
  - Storage is not cleared by reset.
- States:
  - IDLE: req_ready = 1, rsp_valid = 0. On req_valid & req_ready, capture we/addr/wdata/wstrb and evaluate the error condition. Go to WAIT if WAIT_STATES > 0 (counter loads WAIT_STATES-1); otherwise go directly to RESP.
  - WAIT: req_ready = 0, rsp_valid = 0. Counter decrements each cycle. When the counter is 0, go to RESP.
  - RESP: req_ready = 0, rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE.
- Latency: a request accepted at edge k has rsp_valid first sampled high at edge k+1+WAIT_STATES.
  - Back-to-back: minimum issue interval is WAIT_STATES+2 cycles. IDLE is always visited, so req_ready is never high in the same cycle as rsp_valid.
- Commit point: on the edge entering RESP.
  - Stores write the enabled byte lanes.
  - Loads register the addressed word into rsp_rdata.
  - A load therefore always returns data from every store that completed before it.
- Error rules (evaluated on the captured request):
  - misaligned: addr[1:0] != 0.
  - out of range: addr < BASE_ADDR or addr >= BASE_ADDR + DEPTH_WORDS*4.
  - On error: rsp_err = 1, rsp_rdata = 0, no storage write.
- Stores with wstrb = 0: legal no-op; response rsp_err = 0, rsp_rdata = 0.
- Word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits after the range check passes.
- Request signals are sampled only at the accepting edge. Changes while the responder is busy are ignored.
- Reset mid-operation:
  - Reset during WAIT: return to IDLE and drop the transaction; a pending store is not committed.
  - Reset during RESP: the response is withdrawn; a store already committed stays committed.
- rsp_ready high while rsp_valid = 0 has no effect.

Decomposition:
- Shared package dmem_pkg:
  - state encoding IDLE/WAIT/RESP (2 bits);
  - localparam WORD_BYTES = 4;
  - helper function for byte-strobe merge (old word, new word, strobe -> merged word).
- Sub-module dmem_array:
  - DEPTH_WORDS x 32 storage with synchronous byte-strobed write and combinational read by index;
  - no reset.
- dmem_responder holds the FSM, the wait counter, the capture registers, the error check and the response registers.

Test Plan:
- Reset check: assert rst mid-cycle, asynchronously -> req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0 immediately, before the next clock edge.
- Word round trip (WAIT_STATES = 2): store 0xDEADBEEF to 0x10 with wstrb 4'b1111, then load 0x10.
  - Each rsp_valid rises exactly 3 edges after acceptance.
  - Load returns 0xDEADBEEF, rsp_err = 0.
- Byte strobe: store 0x0000AA00 to 0x10 with wstrb 4'b0010, then load 0x10 -> 0xDEADAAEF.
- Errors:
  - Store to 0x12 -> rsp_err = 1, rsp_rdata = 0; load 0x10 afterwards -> still 0xDEADAAEF.
  - Load 0x1000 with DEPTH_WORDS = 1024 -> rsp_err = 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles during a load response.
  - rsp_valid stays 1, rsp_rdata is stable, req_ready stays 0.
  - Handshake completes on the cycle rsp_ready rises; req_ready = 1 the next cycle.
- Reset mid-WAIT: store 0x12345678 to 0x20, assert rst during WAIT, then load 0x20.
  - Load returns the prior contents, not 0x12345678.
- Repeat the round trip with WAIT_STATES = 0 -> rsp_valid is sampled high 1 edge after acceptance.
